// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns architectural HI/LO, drives the pipelined
// multiplier and iterative divider, and provides the MFHI/MFLO busy interlock.
module mdu_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_start,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_cancel,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  input  logic        div_done
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC, DIV} state_t;

  state_t        r_state;
  logic [31:0]   r_hi, r_lo;
  logic [31:0]   r_a, r_b;
  logic          r_sign, r_acc, r_sub;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_prod;
  logic          r_mul_start, r_div_start, r_dz_done;

  logic w_is_mul, w_is_acc, w_is_sub, w_is_div, w_sign, w_mthi, w_mtlo;
  logic w_accept, w_wr_mul, w_wr_acc, w_wr_div;
  logic [63:0] w_acc_res;

  assign w_is_mul = op_code inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8};
  assign w_is_acc = op_code inside {4'd5, 4'd6, 4'd7, 4'd8};
  assign w_is_sub = op_code inside {4'd7, 4'd8};
  assign w_is_div = op_code inside {4'd3, 4'd4};
  assign w_sign   = op_code inside {4'd1, 4'd3, 4'd5, 4'd7};
  assign w_mthi   = (op_code == 4'd9);
  assign w_mtlo   = (op_code == 4'd10);

  assign busy     = (r_state != IDLE);
  assign w_accept = op_valid & ~busy & ~flush;

  // Write strobes are qualified by flush so a cancelled op never reports done.
  assign w_wr_mul = (r_state == MUL) && (r_cnt == '0) && !r_acc && !flush;
  assign w_wr_acc = (r_state == ACC) && !flush;
  assign w_wr_div = (r_state == DIV) && div_done && !flush;

  assign w_acc_res = r_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);

  assign done       = w_wr_mul | w_wr_acc | w_wr_div | r_dz_done;
  assign div_cancel = (r_state == DIV) && flush;

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign mul_start = r_mul_start;
  assign mul_sign  = r_sign;
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign div_start = r_div_start;
  assign div_sign  = r_sign;
  assign div_a     = r_a;
  assign div_b     = r_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hi        <= '0;
      r_lo        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_acc       <= 1'b0;
      r_sub       <= 1'b0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      r_dz_done   <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      r_dz_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mul || w_is_div) begin
              r_a    <= op_a;
              r_b    <= op_b;
              r_sign <= w_sign;
              r_acc  <= w_is_acc;
              r_sub  <= w_is_sub;
            end
            if (w_is_mul) begin
              r_state     <= MUL;
              r_mul_start <= 1'b1;
              r_cnt       <= CW'(MUL_LAT);
            end else if (w_is_div) begin
              // Divide by zero completes immediately without touching HI/LO.
              if (op_b == 32'd0) r_dz_done <= 1'b1;
              else begin
                r_state     <= DIV;
                r_div_start <= 1'b1;
              end
            end else if (w_mthi) begin
              r_hi <= op_a;
            end else if (w_mtlo) begin
              r_lo <= op_a;
            end
          end
        end
        MUL: begin
          if (flush) r_state <= IDLE;
          else if (r_cnt == '0) begin
            if (r_acc) begin
              r_prod  <= mul_result;
              r_state <= ACC;
            end else begin
              {r_hi, r_lo} <= mul_result;
              r_state      <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ACC: begin
          r_state <= IDLE;
          if (!flush) {r_hi, r_lo} <= w_acc_res;
        end
        DIV: begin
          if (flush) r_state <= IDLE;
          else if (div_done) begin
            r_lo    <= div_quot;
            r_hi    <= div_rem;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: two instances (MUL_LAT=1 and 2) share stimulus, each with
// its own multiplier model; one divider model finishes 33 cycles after start.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, op_valid, flush;
  logic [3:0]  op_code;
  logic [31:0] op_a, op_b;
  logic [31:0] div_quot, div_rem;
  logic        div_done, force_dd;

  logic        busy1, done1, ms1, msg1, ds1, dsg1, dc1;
  logic [31:0] hi1, lo1, ma1, mb1, da1, db1;
  logic [63:0] mr1;
  logic        busy2, done2, ms2, msg2, ds2, dsg2, dc2;
  logic [31:0] hi2, lo2, ma2, mb2, da2, db2;
  logic [63:0] mr2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(1)) u1 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .mul_start(ms1),
    .mul_sign(msg1), .mul_a(ma1), .mul_b(mb1), .mul_result(mr1), .div_start(ds1),
    .div_sign(dsg1), .div_a(da1), .div_b(db1), .div_cancel(dc1), .div_quot(div_quot),
    .div_rem(div_rem), .div_done(div_done));

  mdu_ctrl #(.MUL_LAT(2)) u2 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2), .mul_start(ms2),
    .mul_sign(msg2), .mul_a(ma2), .mul_b(mb2), .mul_result(mr2), .div_start(ds2),
    .div_sign(dsg2), .div_a(da2), .div_b(db2), .div_cancel(dc2), .div_quot(div_quot),
    .div_rem(div_rem), .div_done(div_done));

  function automatic logic [63:0] mulf(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (s) mulf = 64'(sa * sb);
    else   mulf = {32'd0, a} * {32'd0, b};
  endfunction

  // Multiplier models: product of the held operands, delayed 1 or 2 cycles.
  logic [63:0] p1_1, p2_1, p2_2;
  always @(posedge clk) begin
    p1_1 <= mulf(ma1, mb1, msg1);
    p2_1 <= mulf(ma2, mb2, msg2);
    p2_2 <= p2_1;
  end
  assign mr1 = p1_1;
  assign mr2 = p2_2;

  // Divider model driven by instance 1; honours cancel.
  int dcnt;
  always @(posedge clk) begin
    if (reset || dc1) dcnt <= 0;
    else if (ds1) begin
      dcnt <= 33;
      if (db1 != 0) begin
        div_quot <= dsg1 ? 32'($signed(da1) / $signed(db1)) : da1 / db1;
        div_rem  <= dsg1 ? 32'($signed(da1) % $signed(db1)) : da1 % db1;
      end
    end else if (dcnt != 0) dcnt <= dcnt - 1;
  end
  assign div_done = (dcnt == 1) | force_dd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [63:0] hl;
    int          lat1, lat2;
    bit          ism, isd, dz;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v, input int idx);
    int l1, l2, b1, b2, lim;
    int m1c, m1f, m2c, m2f, d1c, d2c;
    l1 = 0; l2 = 0; b1 = 0; b2 = 0; m1c = 0; m1f = 0; m2c = 0; m2f = 0; d1c = 0; d2c = 0;
    op_valid = 1'b1; op_code = v.op; op_a = v.a; op_b = v.b;
    @(negedge clk);
    chk($sformatf("v%0d_accept_busy", idx), {busy1, busy2}, 0);
    lim = (v.lat1 == 0) ? 3 : 60;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin op_valid = 1'b0; op_code = 4'd0; end
      @(negedge clk);
      if (done1 && l1 == 0) l1 = c;
      if (done2 && l2 == 0) l2 = c;
      b1 += int'(busy1); b2 += int'(busy2);
      if (ms1 && m1f == 0) m1f = c;
      if (ms2 && m2f == 0) m2f = c;
      m1c += int'(ms1); m2c += int'(ms2);
      d1c += int'(ds1); d2c += int'(ds2);
      if (v.lat1 != 0 && l1 != 0 && l2 != 0 && !busy1 && !busy2) break;
    end
    chk($sformatf("v%0d_hilo1", idx), {hi1, lo1}, v.hl);
    chk($sformatf("v%0d_hilo2", idx), {hi2, lo2}, v.hl);
    chk($sformatf("v%0d_done_cyc1", idx), 64'(l1), 64'(v.lat1));
    chk($sformatf("v%0d_done_cyc2", idx), 64'(l2), 64'(v.lat2));
    chk($sformatf("v%0d_busy_cyc1", idx), 64'(b1), (v.lat1 == 0 || v.dz) ? 0 : 64'(v.lat1));
    chk($sformatf("v%0d_busy_cyc2", idx), 64'(b2), (v.lat2 == 0 || v.dz) ? 0 : 64'(v.lat2));
    chk($sformatf("v%0d_mstart1", idx), {m1c[7:0], m1f[7:0]}, v.ism ? 16'h0101 : 16'h0);
    chk($sformatf("v%0d_mstart2", idx), {m2c[7:0], m2f[7:0]}, v.ism ? 16'h0101 : 16'h0);
    chk($sformatf("v%0d_dstart", idx), {d1c[7:0], d2c[7:0]}, v.isd ? 16'h0101 : 16'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; op_code = 4'd0; op_a = '0; op_b = '0;
    force_dd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl1", {busy1, done1, ms1, ds1, dc1}, 0);
    chk("rst_ctl2", {busy2, done2, ms2, ds2, dc2}, 0);
    chk("rst_hilo", {hi1, lo1, hi2, lo2}, 0);
    chk("rst_opnd", {ma1, mb1, da1, db1}, 0);
    @(posedge clk); #1 reset = 1'b0;

    vecs[0]  = '{4'd1,  32'hFFFFFFFF, 32'd2,  64'hFFFFFFFF_FFFFFFFE, 2, 3, 1, 0, 0};
    vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'd2,  64'h00000001_FFFFFFFE, 2, 3, 1, 0, 0};
    vecs[2]  = '{4'd9,  32'h12345678, 32'd0,  64'h12345678_FFFFFFFE, 0, 0, 0, 0, 0};
    vecs[3]  = '{4'd10, 32'h00000010, 32'd0,  64'h12345678_00000010, 0, 0, 0, 0, 0};
    vecs[4]  = '{4'd6,  32'd4,        32'd4,  64'h12345678_00000020, 3, 4, 1, 0, 0};
    vecs[5]  = '{4'd7,  32'hFFFFFFFF, 32'd1,  64'h12345678_00000021, 3, 4, 1, 0, 0};
    vecs[6]  = '{4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h12345678_00000022, 3, 4, 1, 0, 0};
    vecs[7]  = '{4'd8,  32'h10,       32'h3,  64'h12345677_FFFFFFF2, 3, 4, 1, 0, 0};
    vecs[8]  = '{4'd3,  32'hFFFFFFF9, 32'd2,  64'hFFFFFFFF_FFFFFFFD, 34, 34, 0, 1, 0};
    vecs[9]  = '{4'd4,  32'd100,      32'd7,  64'h00000002_0000000E, 34, 34, 0, 1, 0};
    vecs[10] = '{4'd9,  32'hA,        32'd0,  64'h0000000A_0000000E, 0, 0, 0, 0, 0};
    vecs[11] = '{4'd10, 32'hB,        32'd0,  64'h0000000A_0000000B, 0, 0, 0, 0, 0};
    vecs[12] = '{4'd4,  32'd5,        32'd0,  64'h0000000A_0000000B, 1, 1, 0, 0, 1};
    vecs[13] = '{4'd13, 32'hFFFF,     32'd1,  64'h0000000A_0000000B, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // DIV flushed at wait cycle 5, then a stray div_done must be ignored.
    op_valid = 1'b1; op_code = 4'd3; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1 op_valid = 1'b0;
    @(negedge clk) chk("dflush_start", {ds1, ds2}, 2'b11);
    repeat (4) @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("dflush_cancel", {dc1, dc2}, 2'b11);
    chk("dflush_nodone", {done1, done2}, 0);
    @(posedge clk); #1 flush = 1'b0; force_dd = 1'b1;
    @(negedge clk);
    chk("dflush_idle", {busy1, busy2, dc1, dc2, done1, done2}, 0);
    @(posedge clk); #1 force_dd = 1'b0;
    @(negedge clk);
    chk("dflush_hilo", {hi1, lo1, hi2, lo2}, {64'hA_0000000B, 64'hA_0000000B});
    @(posedge clk); #1;

    // MULT flushed on u1's write cycle.
    op_valid = 1'b1; op_code = 4'd1; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1 op_valid = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk) chk("mflush_nodone1", done1, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("mflush_idle", {busy1, busy2}, 0);
    chk("mflush_hilo", {hi1, lo1, hi2, lo2}, {64'hA_0000000B, 64'hA_0000000B});
    @(posedge clk); #1;

    // MULT flushed on u2's write cycle; u1 has already written.
    op_valid = 1'b1; op_code = 4'd1; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1 op_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) chk("mflush2_done1", done1, 1);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk) chk("mflush2_nodone2", {done2, busy1}, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("mflush2_hilo1", {hi1, lo1}, 64'd15);
    chk("mflush2_hilo2", {hi2, lo2, 31'd0, busy2}, {64'hA_0000000B, 32'd0});
    @(posedge clk); #1;

    // Reset during u1's ACC cycle.
    op_valid = 1'b1; op_code = 4'd5; op_a = 32'd2; op_b = 32'd3;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    @(negedge clk) chk("racc_inacc", {busy1, done1}, 2'b11);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("racc_hilo", {hi1, lo1, hi2, lo2}, 0);
    chk("racc_busy", {busy1, busy2}, 0);
    @(posedge clk); #1;

    // Flush in IDLE drops MTHI and MULT requests.
    op_valid = 1'b1; op_code = 4'd9; op_a = 32'h55; flush = 1'b1;
    @(posedge clk); #1 op_code = 4'd1;
    @(negedge clk) chk("iflush_mthi", {hi1, hi2}, 0);
    @(posedge clk); #1 op_valid = 1'b0; flush = 1'b0;
    @(negedge clk) chk("iflush_mult", {ms1, busy1, ms2, busy2}, 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
